data_sram_slave: RTL and testbench

//  Responder end of the core's SRAM-like data bus (req/wr/size/addr/wdata ->

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/resp_fifo.sv | 78 +++++++
 rtl/data_sram_slave.sv | 94 +++++++++
 tb/tb_data_sram_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared SRAM-like data-bus definitions: transfer-size encodings and byte-enable decode.
package mem_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Misaligned halfword/word accesses decode to an empty mask so the write is dropped.
    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
            default:   be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue: circular buffer whose entries carry the captured load word
// and a saturating age counter that gates when the head may be returned.
module resp_fifo #(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        push_is_load_i,
    input  logic [31:0] push_rdata_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        head_ready_o,
    output logic        head_is_load_o,
    output logic [31:0] head_rdata_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

    logic             is_load_q [DEPTH];
    logic [31:0]      rdata_q   [DEPTH];
    logic [AGE_W-1:0] age_q     [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                is_load_q[i] <= 1'b0;
                rdata_q[i]   <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                // A fresh entry starts at age 1 so the registered data_ok lands LATENCY cycles after accept.
                if (push_i && (wr_ptr_q == PTR_W'(i))) begin
                    is_load_q[i] <= push_is_load_i;
                    rdata_q[i]   <= push_rdata_i;
                    age_q[i]     <= AGE_W'(1);
                end else if (age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign head_ready_o   = (count_q != '0) && (age_q[rd_ptr_q] >= AGE_MAX);
    assign head_is_load_o = is_load_q[rd_ptr_q];
    assign head_rdata_o   = rdata_q[rd_ptr_q];

endmodule

// File: rtl/data_sram_slave.sv
// SRAM-like data-bus responder backed by a word-organised on-chip RAM; returns in-order
// responses after a programmable latency with several requests outstanding.
module data_sram_slave
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        resp_stall,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int WORDS = 2 ** ADDR_WIDTH;

    logic                  accept;
    logic                  fifo_full;
    logic                  head_ready;
    logic                  head_is_load;
    logic                  pop;
    logic [31:0]           head_rdata;
    logic [31:0]           ram_word;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            be;
    logic                  data_ok_q, data_ok_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  unused_addr;

    // Acceptance depends only on occupancy, never on this cycle's pop.
    assign data_addr_ok = data_req & ~fifo_full & ~rst;
    assign accept       = data_addr_ok;
    assign word_idx     = data_addr[ADDR_WIDTH+1:2];
    assign be           = size_to_be(data_size, data_addr[1:0]);
    assign unused_addr  = ^data_addr[31:ADDR_WIDTH+2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            always_ff @(posedge clk) begin
                if (accept && data_wr && be[gi]) begin
                    lane_mem[word_idx] <= data_wdata[8*gi +: 8];
                end
            end
            assign ram_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    // The load word is captured into the queue at the accept edge, so later stores cannot disturb it.
    resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk            (clk),
        .rst            (rst),
        .push_i         (accept),
        .push_is_load_i (~data_wr),
        .push_rdata_i   (ram_word),
        .pop_i          (pop),
        .full_o         (fifo_full),
        .head_ready_o   (head_ready),
        .head_is_load_o (head_is_load),
        .head_rdata_o   (head_rdata)
    );

    assign pop = head_ready & ~resp_stall;

    always_comb begin
        data_ok_d = pop;
        rdata_d   = (pop && head_is_load) ? head_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave (ADDR_WIDTH=14, LATENCY=2, DEPTH=2).
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        resp_stall = 1'b0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [31:0] rq[$];
    int          rc[$];

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    data_sram_slave #(.ADDR_WIDTH(14), .LATENCY(2), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .resp_stall   (resp_stall),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response recorder: captures each data_ok pulse with its cycle number.
    always @(negedge clk) begin
        if (data_data_ok === 1'b1) begin
            rq.push_back(data_rdata);
            rc.push_back(cyc);
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int acc);
        logic ok;
        acc = -1;
        @(negedge clk);
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        for (int n = 0; n < 30 && acc < 0; n++) begin
            #1 ok = data_addr_ok;
            @(posedge clk);
            if (ok === 1'b1) begin
                #1 acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        n_total++;
        if (acc < 0) $display("FAIL accept_timeout: addr %h not accepted, required accept within 30 cycles", a);
        else begin
            n_pass++;
            $display("req wr=%0d size=%0d addr=%h wdata=%h acc_cyc=%0d", wr, sz, a, wd, acc);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        data_req = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] d, output int c);
        d = 'x;
        c = -1;
        for (int n = 0; n < 40 && rq.size() == 0; n++) begin
            @(negedge clk);
            #1;
        end
        n_total++;
        if (rq.size() == 0) $display("FAIL resp_timeout: got no data_ok, required one within 40 cycles");
        else begin
            n_pass++;
            d = rq.pop_front();
            c = rc.pop_front();
            $display("rsp rdata=%h cyc=%0d", d, c);
        end
    endtask

    task automatic xfer(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output int lat);
        int acc, c;
        issue(wr, sz, a, wd, acc);
        idle();
        get_resp(d, c);
        lat = c - acc;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        data_req = 1'b1;
        #1;
        n_total++;
        if (data_addr_ok !== 1'b0) $display("FAIL rst_addr_ok: got %b, required 0", data_addr_ok); else n_pass++;
        n_total++;
        if (data_data_ok !== 1'b0) $display("FAIL rst_data_ok: got %b, required 0", data_data_ok); else n_pass++;
        n_total++;
        if (data_rdata !== 32'h0) $display("FAIL rst_rdata: got %h, required 0", data_rdata); else n_pass++;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 data_req = 1'b1;
        #1;
        n_total++;
        if (data_addr_ok !== 1'b1) $display("FAIL post_rst_addr_ok: got %b, required 1", data_addr_ok); else n_pass++;
        data_req = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int lat;
        xfer(1'b1, SW, 32'h100, 32'h11223344, d, lat);
        n_total++;
        if (d !== 32'h0) $display("FAIL sw_resp_rdata: got %h, required 00000000", d); else n_pass++;
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (lat !== 2) $display("FAIL lw_latency: got %0d, required 2", lat); else n_pass++;
        n_total++;
        if (d !== 32'h11223344) $display("FAIL lw_rdata: got %h, required 11223344", d); else n_pass++;
        @(negedge clk);
        n_total++;
        if (data_data_ok !== 1'b0 || data_rdata !== 32'h0)
            $display("FAIL idle_outputs: got ok=%b rdata=%h, required ok=0 rdata=0", data_data_ok, data_rdata);
        else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        int lat;
        xfer(1'b1, SB, 32'h101, 32'hAAAAAAAA, d, lat);
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (d !== 32'h1122AA44) $display("FAIL sb_merge: got %h, required 1122aa44", d); else n_pass++;
        xfer(1'b1, SH, 32'h102, 32'hBEEFBEEF, d, lat);
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (d !== 32'hBEEFAA44) $display("FAIL sh_merge: got %h, required beefaa44", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int lat;
        int acc[4];
        int rcyc[4];
        logic [31:0] expv[4];
        expv[0] = 32'hBEEFAA44; expv[1] = 32'hA1; expv[2] = 32'hA2; expv[3] = 32'hA3;
        xfer(1'b1, SW, 32'h104, 32'hA1, d, lat);
        xfer(1'b1, SW, 32'h108, 32'hA2, d, lat);
        xfer(1'b1, SW, 32'h10C, 32'hA3, d, lat);
        for (int i = 0; i < 4; i++) issue(1'b0, SW, 32'h100 + 32'(4 * i), 32'h0, acc[i]);
        idle();
        n_total++;
        if (acc[1] - acc[0] !== 1) $display("FAIL b2b_accept01: got gap %0d, required 1", acc[1] - acc[0]); else n_pass++;
        n_total++;
        if (acc[2] - acc[1] !== 2) $display("FAIL b2b_full_stall: got gap %0d, required 2", acc[2] - acc[1]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            get_resp(d, rcyc[i]);
            n_total++;
            if (d !== expv[i]) $display("FAIL b2b_rdata%0d: got %h, required %h", i, d, expv[i]); else n_pass++;
        end
        n_total++;
        if (rcyc[0] - acc[0] !== 2) $display("FAIL b2b_first_lat: got %0d, required 2", rcyc[0] - acc[0]); else n_pass++;
        n_total++;
        if (rcyc[1] - rcyc[0] !== 1 || rcyc[3] - rcyc[2] !== 1)
            $display("FAIL b2b_pulses: got gaps %0d,%0d, required 1,1", rcyc[1] - rcyc[0], rcyc[3] - rcyc[2]);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_total++;
        if (rq.size() !== 0) $display("FAIL b2b_extra_resp: got %0d extra, required 0", rq.size()); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] d0, d1;
        int c0, c1, a0, a1;
        int seen_ok;
        seen_ok = 0;
        resp_stall = 1'b1;
        issue(1'b0, SW, 32'h104, 32'h0, a0);
        issue(1'b0, SW, 32'h108, 32'h0, a1);
        @(negedge clk);
        data_addr = 32'h10C;
        for (int n = 0; n < 10; n++) begin
            #1 if (data_addr_ok !== 1'b0) seen_ok++;
            @(negedge clk);
        end
        n_total++;
        if (seen_ok !== 0) $display("FAIL stall_addr_ok: got %0d cycles high, required 0", seen_ok); else n_pass++;
        n_total++;
        if (rq.size() !== 0) $display("FAIL stall_data_ok: got %0d pulses, required 0", rq.size()); else n_pass++;
        data_req = 1'b0;
        resp_stall = 1'b0;
        get_resp(d0, c0);
        get_resp(d1, c1);
        n_total++;
        if (d0 !== 32'hA1 || d1 !== 32'hA2)
            $display("FAIL stall_release_order: got %h,%h, required 000000a1,000000a2", d0, d1);
        else n_pass++;
        n_total++;
        if (c1 - c0 !== 1) $display("FAIL stall_release_consec: got gap %0d, required 1", c1 - c0); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        int lat;
        xfer(1'b1, SW, 32'h102, 32'hDEADBEEF, d, lat);
        n_total++;
        if (d !== 32'h0) $display("FAIL misal_resp: got %h, required 00000000", d); else n_pass++;
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (d !== 32'hBEEFAA44) $display("FAIL misal_unchanged: got %h, required beefaa44", d); else n_pass++;
        xfer(1'b1, SW, 32'h00010100, 32'h55667788, d, lat);
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (d !== 32'h55667788) $display("FAIL alias_write: got %h, required 55667788", d); else n_pass++;
        xfer(1'b0, SW, 32'h00010104, 32'h0, d, lat);
        n_total++;
        if (d !== 32'hA1) $display("FAIL alias_read: got %h, required 000000a1", d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat, a0, a1;
        resp_stall = 1'b1;
        issue(1'b0, SW, 32'h100, 32'h0, a0);
        issue(1'b0, SW, 32'h104, 32'h0, a1);
        idle();
        repeat (3) @(negedge clk);
        resp_stall = 1'b0;
        data_req = 1'b1;
        data_addr = 32'h108;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (data_data_ok !== 1'b0) $display("FAIL midrst_data_ok: got %b, required 0", data_data_ok); else n_pass++;
        n_total++;
        if (data_rdata !== 32'h0) $display("FAIL midrst_rdata: got %h, required 0", data_rdata); else n_pass++;
        n_total++;
        if (data_addr_ok !== 1'b0) $display("FAIL midrst_addr_ok: got %b, required 0", data_addr_ok); else n_pass++;
        data_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if (rq.size() !== 0) $display("FAIL midrst_stale: got %0d responses, required 0", rq.size()); else n_pass++;
        xfer(1'b0, SW, 32'h100, 32'h0, d, lat);
        n_total++;
        if (d !== 32'h55667788) $display("FAIL midrst_persist0: got %h, required 55667788", d); else n_pass++;
        xfer(1'b0, SW, 32'h104, 32'h0, d, lat);
        n_total++;
        if (d !== 32'hA1) $display("FAIL midrst_persist1: got %h, required 000000a1", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_back_to_back();
        test_stall();
        test_misaligned();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1);
    end

endmodule
